game_status: RTL and testbench

//  Collision/score/lives controller for the square-dodge game. Consumes the player square

---
 rtl/game_pkg.sv | 30 +++
 rtl/aabb_overlap.sv | 32 +++
 rtl/game_status.sv | 201 ++++++++++++++++++++
 tb/tb_game_status.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and field layout for the square-dodge game status logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    // Controller states: waiting, per-frame idle, obstacle scan, verdict, finished
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_SCAN = 3'd2,
        ST_EVAL = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    localparam int COORD_W  = 10;
    localparam int PLAYER_W = 20;
    localparam int ENTRY_W  = 40;
    localparam int SCORE_W  = 16;

    // Player position field offsets
    localparam int POS_X = 0;
    localparam int POS_Y = 10;

    // Obstacle entry field offsets; dx/dy are motion data and not used here
    localparam int ENTRY_X  = 0;
    localparam int ENTRY_Y  = 10;
    localparam int ENTRY_DX = 20;
    localparam int ENTRY_DY = 30;

endpackage

// File: rtl/aabb_overlap.sv
// Axis-aligned square overlap test between the player and one obstacle.
// Latency: combinational.
// Backpressure: none.
module aabb_overlap
    import game_pkg::*;
#(
    parameter int A_SIZE = 20,
    parameter int B_SIZE = 20
) (
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    output logic               overlap
);

    // One extra bit so x+size near the right/bottom edge never wraps to a small value
    logic [COORD_W:0] ax_w, ay_w, bx_w, by_w;

    // Strict compares: squares that only share an edge are not overlapping
    always_comb begin
        ax_w    = {1'b0, ax};
        ay_w    = {1'b0, ay};
        bx_w    = {1'b0, bx};
        by_w    = {1'b0, by};
        overlap = (ax_w < bx_w + (COORD_W+1)'(B_SIZE)) &&
                  (bx_w < ax_w + (COORD_W+1)'(A_SIZE)) &&
                  (ay_w < by_w + (COORD_W+1)'(B_SIZE)) &&
                  (by_w < ay_w + (COORD_W+1)'(A_SIZE));
    end

endmodule

// File: rtl/game_status.sv
// Collision/score/lives controller: per-frame serial obstacle scan, lives, score, game state.
// Latency: tick in cycle T -> scan T+1..T+N_OBST, verdict T+N_OBST+1, hit pulse T+N_OBST+2.
// Backpressure: none; refresh_tick outside PLAY is dropped. GAME_STATUS_BCD_EN selects BCD score.
module game_status
    import game_pkg::*;
#(
    parameter int N_OBST       = 16,
    parameter int PLAYER_SIZE  = 20,
    parameter int OBST_SIZE    = 20,
    parameter int LIVES_INIT   = 3,
    parameter int GRACE_FRAMES = 60,
    parameter int SCORE_DIV    = 60
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    input  logic                       refresh_tick,
    input  logic                       start,
    input  logic [PLAYER_W-1:0]        player_pos,
    input  logic [ENTRY_W*N_OBST-1:0]  obst_pos,
    output logic                       status,
    output logic                       game_over,
    output logic [2:0]                 lives,
    output logic [SCORE_W-1:0]         score,
    output logic                       hit,
    output logic                       busy
);

    localparam int IDX_W   = (N_OBST > 1) ? $clog2(N_OBST) : 1;
    localparam int GRACE_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
    localparam int FRAME_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OBST - 1);

    state_t               state_q, state_d;
    logic                 start_q;
    logic                 start_rise;
    logic [COORD_W-1:0]   player_x_q, player_y_q;
    logic [COORD_W-1:0]   obst_x_q [N_OBST];
    logic [COORD_W-1:0]   obst_y_q [N_OBST];
    logic [IDX_W-1:0]     idx_q;
    logic                 hit_flag_q;
    logic                 overlap_cur;
    logic                 lose_life;
    logic [2:0]           lives_q, lives_dec;
    logic [SCORE_W-1:0]   score_q;
    logic [GRACE_W-1:0]   grace_q;
    logic [FRAME_W-1:0]   frame_q;
    logic                 hit_q;
    logic [N_OBST*2*COORD_W-1:0] unused_dxdy;

    // Score increment, saturating; decimal digits with carry when BCD display is enabled
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
`ifdef GAME_STATUS_BCD_EN
        logic carry;
        r     = s;
        carry = (s != 16'h9999);
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] >= 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
`else
        r = (s == 16'hFFFF) ? s : s + 16'd1;
`endif
        return r;
    endfunction

    // Obstacle motion fields ride along in the vector but play no part in collisions
    always_comb begin
        unused_dxdy = '0;
        for (int i = 0; i < N_OBST; i++) begin
            unused_dxdy[i*2*COORD_W +: 2*COORD_W] = obst_pos[i*ENTRY_W + ENTRY_DX +: 2*COORD_W];
        end
    end

    assign start_rise = start & ~start_q;
    assign lose_life  = hit_flag_q && (grace_q == '0);
    assign lives_dec  = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;

    aabb_overlap #(
        .A_SIZE (PLAYER_SIZE),
        .B_SIZE (OBST_SIZE)
    ) u_overlap (
        .ax      (player_x_q),
        .ay      (player_y_q),
        .bx      (obst_x_q[idx_q]),
        .by      (obst_y_q[idx_q]),
        .overlap (overlap_cur)
    );

    // State register
    always_ff @(posedge clk_100MHz) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d   = state_q;
        status    = 1'b0;
        game_over = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: if (start_rise) state_d = ST_PLAY;
            ST_PLAY: begin
                status = 1'b1;
                if (refresh_tick) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                status = 1'b1;
                busy   = 1'b1;
                if (idx_q == IDX_LAST) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                status  = 1'b1;
                busy    = 1'b1;
                state_d = (lose_life && lives_dec == 3'd0) ? ST_OVER : ST_PLAY;
            end
            ST_OVER: begin
                game_over = 1'b1;
                if (start_rise) state_d = ST_PLAY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Snapshot, scan accumulation, lives/score/grace bookkeeping
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            start_q    <= 1'b1;
            player_x_q <= '0;
            player_y_q <= '0;
            for (int i = 0; i < N_OBST; i++) begin
                obst_x_q[i] <= '0;
                obst_y_q[i] <= '0;
            end
            idx_q      <= '0;
            hit_flag_q <= 1'b0;
            lives_q    <= 3'd0;
            score_q    <= '0;
            grace_q    <= '0;
            frame_q    <= '0;
            hit_q      <= 1'b0;
        end else begin
            start_q <= start;
            hit_q   <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_rise) begin
                        lives_q <= 3'(LIVES_INIT);
                        score_q <= '0;
                        grace_q <= '0;
                        frame_q <= '0;
                    end
                end
                ST_PLAY: begin
                    if (refresh_tick) begin
                        player_x_q <= player_pos[POS_X +: COORD_W];
                        player_y_q <= player_pos[POS_Y +: COORD_W];
                        for (int i = 0; i < N_OBST; i++) begin
                            obst_x_q[i] <= obst_pos[i*ENTRY_W + ENTRY_X +: COORD_W];
                            obst_y_q[i] <= obst_pos[i*ENTRY_W + ENTRY_Y +: COORD_W];
                        end
                        idx_q      <= '0;
                        hit_flag_q <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    hit_flag_q <= hit_flag_q | overlap_cur;
                    idx_q      <= idx_q + 1'b1;
                end
                ST_EVAL: begin
                    if (lose_life) begin
                        lives_q <= lives_dec;
                        grace_q <= GRACE_W'(GRACE_FRAMES);
                        hit_q   <= 1'b1;
                    end else begin
                        if (grace_q != '0) grace_q <= grace_q - 1'b1;
                        if (frame_q == FRAME_W'(SCORE_DIV - 1)) begin
                            frame_q <= '0;
                            score_q <= score_inc(score_q);
                        end else begin
                            frame_q <= frame_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign lives = lives_q;
    assign score = score_q;
    assign hit   = hit_q;

endmodule

// File: tb/tb_game_status.sv
// Bench for game_status: directed scenarios with literal expectations plus randomized traffic,
// all outputs compared every cycle against a frame-level model of the game rules.
// Honours GAME_STATUS_BCD_EN for the expected score encoding.
module tb_game_status;

    localparam int N  = 16;
    localparam int PS = 20;
    localparam int OS = 20;
    localparam int LI = 3;
    localparam int GF = 60;
    localparam int SD = 60;

    logic            clk_100MHz = 1'b0;
    logic            reset = 1'b1;
    logic            refresh_tick = 1'b0;
    logic            start = 1'b0;
    logic [19:0]     player_pos = '0;
    logic [40*N-1:0] obst_pos = '0;
    logic            status, game_over, hit, busy;
    logic [2:0]      lives;
    logic [15:0]     score;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // frame-level model state
    int m_run, m_over, m_cd, m_hitflag, m_lives, m_points, m_grace, m_frames, m_hit, m_prev;

    game_status #(
        .N_OBST(N), .PLAYER_SIZE(PS), .OBST_SIZE(OS),
        .LIVES_INIT(LI), .GRACE_FRAMES(GF), .SCORE_DIV(SD)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .start        (start),
        .player_pos   (player_pos),
        .obst_pos     (obst_pos),
        .status       (status),
        .game_over    (game_over),
        .lives        (lives),
        .score        (score),
        .hit          (hit),
        .busy         (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int any_overlap(input logic [19:0] pp, input logic [40*N-1:0] ob);
        int px, py, ox, oy, r;
        px = int'(pp[9:0]);
        py = int'(pp[19:10]);
        r  = 0;
        for (int i = 0; i < N; i++) begin
            ox = int'(ob[40*i +: 10]);
            oy = int'(ob[40*i+10 +: 10]);
            if (px < ox + OS && ox < px + PS && py < oy + OS && oy < py + PS) r = 1;
        end
        return r;
    endfunction

    function automatic int exp_score(input int pts);
        int p;
`ifdef GAME_STATUS_BCD_EN
        p = (pts > 9999) ? 9999 : pts;
        return ((p / 1000) << 12) | (((p / 100) % 10) << 8) | (((p / 10) % 10) << 4) | (p % 10);
`else
        p = (pts > 65535) ? 65535 : pts;
        return p;
`endif
    endfunction

    // Model: one step per clock edge, from the same inputs the DUT samples
    task automatic model_step();
        int rise;
        if (reset) begin
            m_run = 0; m_over = 0; m_cd = 0; m_hitflag = 0; m_lives = 0;
            m_points = 0; m_grace = 0; m_frames = 0; m_hit = 0; m_prev = 1;
            return;
        end
        m_hit  = 0;
        rise   = (start && !m_prev) ? 1 : 0;
        m_prev = start ? 1 : 0;
        if (m_run == 1) begin
            if (m_cd == 0) begin
                if (refresh_tick) begin
                    m_hitflag = any_overlap(player_pos, obst_pos);
                    m_cd      = N + 1;
                end
            end else begin
                m_cd--;
                if (m_cd == 0) begin
                    if (m_hitflag == 1 && m_grace == 0) begin
                        if (m_lives > 0) m_lives--;
                        m_grace = GF;
                        m_hit   = 1;
                        if (m_lives == 0) begin m_run = 0; m_over = 1; end
                    end else begin
                        if (m_grace > 0) m_grace--;
                        m_frames++;
                        if (m_frames == SD) begin m_frames = 0; m_points++; end
                    end
                end
            end
        end else if (rise == 1) begin
            m_run = 1; m_over = 0; m_cd = 0; m_lives = LI;
            m_points = 0; m_grace = 0; m_frames = 0;
        end
    endtask

    initial forever begin
        @(posedge clk_100MHz);
        model_step();
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk_100MHz);
        if (chk_en) begin
            chk("status",    int'(status),    m_run);
            chk("game_over", int'(game_over), m_over);
            chk("lives",     int'(lives),     m_lives);
            chk("score",     int'(score),     exp_score(m_points));
            chk("hit",       int'(hit),       m_hit);
            chk("busy",      int'(busy),      (m_run == 1 && m_cd > 0) ? 1 : 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic set_player(input int x, input int y);
        player_pos = {10'(y), 10'(x)};
    endtask

    task automatic set_obst(input int i, input int x, input int y);
        obst_pos[40*i +: 40] = {10'($urandom), 10'($urandom), 10'(y), 10'(x)};
    endtask

    task automatic clear_obst();
        for (int i = 0; i < N; i++) set_obst(i, $urandom_range(0, 1023), 0);
    endtask

    // One frame: tick pulse then a fixed window; returns hit pulses seen
    task automatic frame(output int nh);
        nh = 0;
        refresh_tick = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            refresh_tick = 1'b0;
            if (hit === 1'b1) nh++;
        end
    endtask

    task automatic frames(input int cnt, output int nh);
        int h;
        nh = 0;
        for (int f = 0; f < cnt; f++) begin frame(h); nh += h; end
    endtask

    task automatic restart();
        start = 1'b0; step(1);
        start = 1'b1; step(1);
    endtask

    initial begin
        int nh;
        set_player(300, 220);
        clear_obst();
        reset = 1'b1; start = 1'b0;
        step(1);
        chk_en = 1;
        step(2);
        chk("rst_status", int'(status), 0);
        chk("rst_lives",  int'(lives),  0);
        chk("rst_score",  int'(score),  0);
        chk("rst_busy",   int'(busy),   0);
        reset = 1'b0;
        step(1);
        start = 1'b1; step(1);
        chk("start_status", int'(status), 1);
        chk("start_lives",  int'(lives),  3);

        // no overlap for 100 frames
        frames(100, nh);
        chk("noovl_hits",  nh, 0);
        chk("noovl_lives", int'(lives), 3);
        chk("noovl_score", int'(score), 1);

        // single hit with exact timing
        set_obst(5, 310, 230);
        refresh_tick = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            refresh_tick = 1'b0;
            if (k <= 17) chk("hit_busy_window", int'(busy), 1);
            if (k == 17) chk("hit_early", int'(hit), 0);
            if (k == 18) begin
                chk("hit_pulse", int'(hit), 1);
                chk("hit_lives", int'(lives), 2);
                chk("hit_busy_end", int'(busy), 0);
            end
            if (k == 19) chk("hit_len", int'(hit), 0);
        end

        // grace window, then second and third hits
        frames(60, nh);
        chk("grace_hits", nh, 0);
        frames(1, nh);
        chk("grace_rehit", nh, 1);
        chk("grace_lives", int'(lives), 1);
        frames(60, nh);
        frames(1, nh);
        chk("over_hit",    nh, 1);
        chk("over_flag",   int'(game_over), 1);
        chk("over_status", int'(status), 0);
        chk("over_lives",  int'(lives), 0);
        frames(2, nh);
        chk("over_busy", int'(busy), 0);
        clear_obst();
        restart();
        chk("restart_lives",  int'(lives), 3);
        chk("restart_score",  int'(score), 0);
        chk("restart_status", int'(status), 1);

        // edge cases
        set_obst(3, 320, 220);
        frames(1, nh);
        chk("edge_touch", nh, 0);
        set_player(5, 220);
        set_obst(3, 1015, 220);
        frames(1, nh);
        chk("edge_nowrap", nh, 0);
        set_player(300, 220);
        set_obst(3, 319, 220);
        frames(1, nh);
        chk("edge_overlap", nh, 1);
        chk("edge_lives", int'(lives), 2);

        // reset in the middle of the scan
        refresh_tick = 1'b1;
        step(1);
        refresh_tick = 1'b0;
        step(7);
        reset = 1'b1;
        step(1);
        chk("midrst_status", int'(status), 0);
        chk("midrst_lives",  int'(lives),  0);
        chk("midrst_busy",   int'(busy),   0);
        reset = 1'b0;
        clear_obst();
        restart();

        // a tick while busy must not be queued
        refresh_tick = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            refresh_tick = (k == 5) ? 1'b1 : 1'b0;
            if (k == 10) chk("busytick_busy", int'(busy), 1);
            if (k >= 18) chk("busytick_noqueue", int'(busy), 0);
        end

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            int px, py, i;
            refresh_tick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) start = ~start;
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
                end else begin
                    px = $urandom_range(290, 310); py = $urandom_range(210, 230);
                end
                set_player(px, py);
            end
            px = int'(player_pos[9:0]);
            py = int'(player_pos[19:10]);
            i  = $urandom_range(0, N - 1);
            if ($urandom_range(0, 1) == 0)
                set_obst(i, (px + $urandom_range(0, 60) - 30) & 1023,
                            (py + $urandom_range(0, 60) - 30) & 1023);
            else
                set_obst(i, $urandom_range(0, 1023), $urandom_range(0, 1023));
            step(1);
        end
        refresh_tick = 1'b0;

        // long run for score digits
        reset = 1'b1; step(1);
        reset = 1'b0;
        set_player(300, 220);
        clear_obst();
        restart();
        frames(540, nh);
        chk("score_9", int'(score), 16'h0009);
        frames(60, nh);
`ifdef GAME_STATUS_BCD_EN
        chk("score_10", int'(score), 16'h0010);
`else
        chk("score_10", int'(score), 10);
`endif
        chk("long_hits", nh, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
